// File: rtl/qspi_flash_ctrl.sv
// Read-only quad-SPI flash controller: each mem_rstrb becomes a Quad Output Fast Read (0x6B).
// Define QSPI_CONT_READ_EN to keep CS low after a read and stream the next sequential word without CMD/ADDR.
module qspi_flash_ctrl #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DESEL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rstrb,
  output logic [31:0]           mem_rdata,
  output logic                  mem_rbusy,
  output logic                  spi_clk,
  output logic                  spi_cs_n,
  output logic [3:0]            spi_io_out,
  output logic [3:0]            spi_io_oe,
  input  logic [3:0]            spi_io_in
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DESEL = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
`ifdef QSPI_CONT_READ_EN
  localparam logic [2:0] S_HOLD  = 3'd6;
`endif
  localparam int CNT_W = (DESEL_CYCLES > 48) ? $clog2(DESEL_CYCLES) + 1 : 6;
  localparam logic [CNT_W-1:0] DESEL_LAST = CNT_W'(DESEL_CYCLES - 1);

  // Nibbles arrive byte0-high first; the flash byte at +0 belongs in bits [7:0].
  function automatic logic [31:0] le_word(input logic [31:0] nibs);
    return {nibs[7:0], nibs[15:8], nibs[23:16], nibs[31:24]};
  endfunction

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           shift_q, shift_d;
  logic [27:0]           nib_q, nib_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rbusy_q, rbusy_d;
  logic                  sck_q, sck_d;
  logic                  cs_n_q, cs_n_d;
  logic [3:0]            io_out_q, io_out_d;
  logic [3:0]            io_oe_q, io_oe_d;
  logic [ADDR_WIDTH-1:0] word_addr_s;
  logic [23:0]           addr24_s;
  logic [31:0]           word_s;
  logic                  active_s;
  logic                  drive_s;
`ifdef QSPI_CONT_READ_EN
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
`endif

  assign word_addr_s = mem_addr & ~ADDR_WIDTH'(3);
  assign addr24_s    = 24'(addr_q);
  assign word_s      = {nib_q, spi_io_in};

  // cnt_q counts clk cycles inside a state; its LSB is the SCK phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    addr_d   = addr_q;
    shift_d  = shift_q;
    nib_d    = nib_q;
    rdata_d  = rdata_q;
    rbusy_d  = rbusy_q;
`ifdef QSPI_CONT_READ_EN
    next_addr_d = next_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mem_rstrb) begin
          addr_d  = word_addr_s;
          rbusy_d = 1'b1;
          state_d = S_DESEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DESEL: begin
        if (cnt_q == DESEL_LAST) begin
          state_d = S_CMD;
          cnt_d   = '0;
          shift_d = {8'h6B, addr24_s};
        end else begin
          state_d = S_DESEL;
        end
      end
      S_CMD, S_ADDR: begin
        if (cnt_q[0]) begin
          shift_d = {shift_q[30:0], 1'b0};
        end else begin
          shift_d = shift_q;
        end
        if (state_q == S_CMD && cnt_q == CNT_W'(15)) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end else if (state_q == S_ADDR && cnt_q == CNT_W'(47)) begin
          state_d = S_DUMMY;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_DUMMY: begin
        if (cnt_q == CNT_W'(15)) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          state_d = S_DUMMY;
        end
      end
      S_DATA: begin
        if (cnt_q[0]) begin
          nib_d = word_s[27:0];
        end else begin
          nib_d = nib_q;
        end
        if (cnt_q == CNT_W'(15)) begin
          rdata_d = le_word(word_s);
          rbusy_d = 1'b0;
          cnt_d   = '0;
`ifdef QSPI_CONT_READ_EN
          state_d     = S_HOLD;
          next_addr_d = addr_q + ADDR_WIDTH'(4);
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef QSPI_CONT_READ_EN
      S_HOLD: begin
        cnt_d = '0;
        if (mem_rstrb) begin
          addr_d  = word_addr_s;
          rbusy_d = 1'b1;
          state_d = (word_addr_s == next_addr_q) ? S_DATA : S_DESEL;
        end else begin
          state_d = S_HOLD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin values are derived from the next state so every SPI output leaves a flop.
    active_s = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DUMMY) || (state_d == S_DATA);
    drive_s  = (state_d == S_CMD) || (state_d == S_ADDR);
    sck_d    = active_s & cnt_d[0];
`ifdef QSPI_CONT_READ_EN
    cs_n_d   = ~(active_s || (state_d == S_HOLD));
`else
    cs_n_d   = ~active_s;
`endif
    io_oe_d  = drive_s ? 4'b1101 : 4'b0000;
    io_out_d = drive_s ? {3'b110, shift_d[31]} : 4'b0000;
  end

  // State and output registers; reset releases CS immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      shift_q  <= 32'h0000_0000;
      nib_q    <= 28'h000_0000;
      rdata_q  <= 32'h0000_0000;
      rbusy_q  <= 1'b0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      io_out_q <= 4'b0000;
      io_oe_q  <= 4'b0000;
`ifdef QSPI_CONT_READ_EN
      next_addr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      nib_q    <= nib_d;
      rdata_q  <= rdata_d;
      rbusy_q  <= rbusy_d;
      sck_q    <= sck_d;
      cs_n_q   <= cs_n_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
`ifdef QSPI_CONT_READ_EN
      next_addr_q <= next_addr_d;
`endif
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_rbusy  = rbusy_q;
  assign spi_clk    = sck_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_io_out = io_out_q;
  assign spi_io_oe  = io_oe_q;
endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Self-checking bench for qspi_flash_ctrl: a behavioural quad-SPI flash plus a word-level read model.
module tb_qspi_flash_ctrl;
  localparam int D        = 2;
  localparam int FULL_LAT = D + 96;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        spi_clk;
  logic        spi_cs_n;
  logic [3:0]  spi_io_out;
  logic [3:0]  spi_io_oe;
  logic [3:0]  spi_io_in;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  qspi_flash_ctrl #(.ADDR_WIDTH(24), .DESEL_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata),
    .mem_rbusy  (mem_rbusy),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_io_out (spi_io_out),
    .spi_io_oe  (spi_io_oe),
    .spi_io_in  (spi_io_in)
  );

  // Flash contents: explicit bytes where set, otherwise a hash of the address.
  logic [7:0] mem [logic [23:0]];
  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = {8'h00, a} * 32'h9E37_79B1;
    return h[31:24];
  endfunction

  // Flash side: decode command/address on IO0, stream nibbles after 8 dummy clocks.
  int          n_sck = 0;
  int          cmd_cnt = 0;
  int          cs_rise = 0;
  int          sck_cnt = 0;
  int          gap_err = 0;
  int          oe_err = 0;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_sr = 24'h0;
  logic [23:0] f_addr = 24'h0;
  time         sck_prev = 0;
  bit          sck_prev_ok = 1'b0;

  always @(posedge spi_cs_n) begin
    n_sck = 0;
    cs_rise++;
  end

  always @(posedge spi_clk) begin
    if (!spi_cs_n) begin
      if (n_sck < 8) f_cmd = {f_cmd[6:0], spi_io_out[0]};
      else if (n_sck < 32) f_sr = {f_sr[22:0], spi_io_out[0]};
      if (n_sck == 7) cmd_cnt++;
      if (n_sck == 31) f_addr = f_sr;
      n_sck++;
    end
    sck_cnt++;
    if (sck_prev_ok && (($time - sck_prev) != 64'd20)) gap_err++;
    sck_prev = $time;
    sck_prev_ok = 1'b1;
  end

  always @(negedge spi_clk) begin
    int i;
    logic [7:0] b;
    if (!spi_cs_n && n_sck >= 40) begin
      i = n_sck - 40;
      b = byte_at(f_addr + 24'(i / 2));
      #1 spi_io_in = (i % 2 == 0) ? b[7:4] : b[3:0];
    end
  end

  // Output-enable expectation from the flash's view of the bit position.
  always @(negedge clk) begin
    logic [3:0] e;
    if (spi_cs_n) e = 4'b0000;
    else if (n_sck < 32 || (n_sck == 32 && spi_clk)) e = 4'b1101;
    else e = 4'b0000;
    if (spi_io_oe !== e) oe_err++;
    if (e == 4'b1101 && spi_io_out[3:2] !== 2'b11) oe_err++;
  end

  // Word-level reference: little-endian aligned word, latency from the continuous-read rule.
  logic [31:0] m_rdata = 32'h0;
  bit          m_hold = 1'b0;
  logic [23:0] m_next = 24'h0;

  task automatic model_reset();
    m_rdata = 32'h0;
    m_hold  = 1'b0;
  endtask

  task automatic model_read(input logic [23:0] a, output int lat, output logic [31:0] d);
    logic [23:0] w;
    w = a & 24'hFFFFFC;
    d = {byte_at(w + 24'd3), byte_at(w + 24'd2), byte_at(w + 24'd1), byte_at(w)};
`ifdef QSPI_CONT_READ_EN
    lat = (m_hold && w == m_next) ? 16 : FULL_LAT;
    m_hold = 1'b1;
    m_next = w + 24'd4;
`else
    lat = FULL_LAT;
`endif
    m_rdata = d;
  endtask

  // One read starting at a negedge; leaves observations in r_* and returns at a negedge.
  int          r_lat, r_ncmd, r_ncsr, r_nsck, r_gap;
  logic [31:0] r_data, r_rdata1;
  logic        r_busy1;

  task automatic do_read(input logic [23:0] a, input bit pulse);
    int c0, s0, g0;
    c0 = cmd_cnt; s0 = cs_rise; g0 = gap_err;
    sck_cnt = 0; sck_prev_ok = 1'b0;
    mem_addr = a; mem_rstrb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rstrb = 1'b0;
    r_busy1 = mem_rbusy; r_rdata1 = mem_rdata;
    r_lat = 0;
    for (int k = 1; k <= 400; k++) begin
      if (pulse) begin
        mem_rstrb = (k % 5 == 2);
        mem_addr  = a ^ 24'h0F0F00;
      end
      @(posedge clk);
      @(negedge clk);
      if (!mem_rbusy) begin
        r_lat = k;
        break;
      end
    end
    mem_rstrb = 1'b0; mem_addr = a;
    r_data = mem_rdata;
    r_ncmd = cmd_cnt - c0; r_ncsr = cs_rise - s0; r_nsck = sck_cnt; r_gap = gap_err - g0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_rstrb = 1'b0; mem_addr = 24'h0; spi_io_in = 4'h0;
    model_reset();
    #12;
    total++; if (spi_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); else passed++;
    total++; if (spi_clk !== 1'b0) $display("FAIL reset_sck: got %b want 0", spi_clk); else passed++;
    total++; if (spi_io_oe !== 4'b0000) $display("FAIL reset_oe: got %b want 0000", spi_io_oe); else passed++;
    total++; if (spi_io_out !== 4'b0000) $display("FAIL reset_io_out: got %b want 0000", spi_io_out); else passed++;
    total++; if (mem_rbusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mem_rbusy); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", mem_rdata); else passed++;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (mem_rbusy !== 1'b0 || spi_cs_n !== 1'b1) $display("FAIL idle_after_reset: busy %b cs_n %b want 0/1", mem_rbusy, spi_cs_n); else passed++;
  endtask

  task automatic test_reset_abort();
    int el;
    logic [31:0] ed;
    mem_addr = 24'h345678; mem_rstrb = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_rstrb = 1'b0;
    for (int k = 0; k < 300 && n_sck < 44; k++) @(negedge clk);
    total++; if (n_sck != 44) $display("FAIL abort_reach_data: got %0d sck want 44", n_sck); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (spi_cs_n !== 1'b1) $display("FAIL abort_cs_n: got %b want 1", spi_cs_n); else passed++;
    total++; if (mem_rbusy !== 1'b0) $display("FAIL abort_busy: got %b want 0", mem_rbusy); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL abort_rdata: got %h want 0", mem_rdata); else passed++;
    total++; if (spi_clk !== 1'b0) $display("FAIL abort_sck: got %b want 0", spi_clk); else passed++;
    @(negedge clk); reset = 1'b0;
    model_reset();
    model_read(24'h123450, el, ed);
    do_read(24'h123450, 1'b0);
    total++; if (r_lat != el) $display("FAIL abort_recover_lat: got %0d want %0d", r_lat, el); else passed++;
    total++; if (r_data !== ed) $display("FAIL abort_recover_data: got %h want %h", r_data, ed); else passed++;
  endtask

  task automatic test_unaligned();
    int el;
    logic [31:0] ed;
    model_read(24'h810006, el, ed);
    do_read(24'h810006, 1'b0);
    total++; if (f_addr !== 24'h810004) $display("FAIL unaligned_addr_phase: got %h want 810004", f_addr); else passed++;
    total++; if (r_data !== ed) $display("FAIL unaligned_data: got %h want %h", r_data, ed); else passed++;
    total++; if (r_lat != el) $display("FAIL unaligned_lat: got %0d want %0d", r_lat, el); else passed++;
  endtask

  task automatic test_basic();
    int el;
    logic [31:0] ed, prev;
    mem[24'h810000] = 8'h13; mem[24'h810001] = 8'h00;
    mem[24'h810002] = 8'h00; mem[24'h810003] = 8'h00;
    prev = m_rdata;
    model_read(24'h810000, el, ed);
    do_read(24'h810000, 1'b0);
    total++; if (r_busy1 !== 1'b1) $display("FAIL basic_busy_after_t0: got %b want 1", r_busy1); else passed++;
    total++; if (r_rdata1 !== prev) $display("FAIL basic_rdata_held: got %h want %h", r_rdata1, prev); else passed++;
    total++; if (f_cmd !== 8'h6B) $display("FAIL basic_cmd: got %h want 6b", f_cmd); else passed++;
    total++; if (f_addr !== 24'h810000) $display("FAIL basic_addr: got %h want 810000", f_addr); else passed++;
    total++; if (r_data !== 32'h0000_0013) $display("FAIL basic_data: got %h want 00000013", r_data); else passed++;
    total++; if (r_lat != 98) $display("FAIL basic_lat: got %0d want 98", r_lat); else passed++;
    total++; if (r_nsck != 48) $display("FAIL basic_sck_count: got %0d want 48", r_nsck); else passed++;
    total++; if (r_gap != 0) $display("FAIL basic_sck_period: got %0d bad gaps want 0", r_gap); else passed++;
    if (el != 98) $display("model latency differs from 98: %0d", el);
  endtask

  task automatic test_cont();
    int el;
    logic [31:0] ed;
    model_read(24'h810004, el, ed);
    do_read(24'h810004, 1'b0);
    total++; if (r_data !== ed) $display("FAIL cont_data: got %h want %h", r_data, ed); else passed++;
    total++; if (r_lat != el) $display("FAIL cont_lat: got %0d want %0d", r_lat, el); else passed++;
`ifdef QSPI_CONT_READ_EN
    total++; if (r_ncmd != 0) $display("FAIL cont_no_cmd: got %0d cmds want 0", r_ncmd); else passed++;
    total++; if (r_ncsr != 0) $display("FAIL cont_cs_low: got %0d cs rises want 0", r_ncsr); else passed++;
    total++; if (r_nsck != 8) $display("FAIL cont_sck_count: got %0d want 8", r_nsck); else passed++;
    total++; if (spi_cs_n !== 1'b0) $display("FAIL cont_hold_cs: got %b want 0", spi_cs_n); else passed++;
`else
    total++; if (r_ncmd != 1) $display("FAIL seq_full_cmd: got %0d cmds want 1", r_ncmd); else passed++;
    total++; if (spi_cs_n !== 1'b1) $display("FAIL seq_cs_released: got %b want 1", spi_cs_n); else passed++;
`endif
    model_read(24'h820000, el, ed);
    do_read(24'h820000, 1'b0);
    total++; if (r_lat != FULL_LAT) $display("FAIL jump_lat: got %0d want %0d", r_lat, FULL_LAT); else passed++;
    total++; if (r_data !== ed) $display("FAIL jump_data: got %h want %h", r_data, ed); else passed++;
    total++; if (f_addr !== 24'h820000) $display("FAIL jump_addr: got %h want 820000", f_addr); else passed++;
`ifdef QSPI_CONT_READ_EN
    total++; if (r_ncsr != 1) $display("FAIL jump_cs_rise: got %0d want 1", r_ncsr); else passed++;
`endif
  endtask

  task automatic test_busy_strobe();
    int el;
    logic [31:0] ed;
    model_read(24'h5A5A50, el, ed);
    do_read(24'h5A5A50, 1'b1);
    total++; if (r_lat != el) $display("FAIL busy_strobe_lat: got %0d want %0d", r_lat, el); else passed++;
    total++; if (r_data !== ed) $display("FAIL busy_strobe_data: got %h want %h", r_data, ed); else passed++;
    total++; if (f_addr !== 24'h5A5A50) $display("FAIL busy_strobe_addr: got %h want 5a5a50", f_addr); else passed++;
    total++; if (r_ncmd != 1) $display("FAIL busy_strobe_cmds: got %0d want 1", r_ncmd); else passed++;
  endtask

  task automatic test_wrap();
    int el;
    logic [31:0] ed;
    model_read(24'hFFFFFF, el, ed);
    do_read(24'hFFFFFF, 1'b0);
    total++; if (f_addr !== 24'hFFFFFC) $display("FAIL top_addr: got %h want fffffc", f_addr); else passed++;
    total++; if (r_data !== ed) $display("FAIL top_data: got %h want %h", r_data, ed); else passed++;
    model_read(24'h000001, el, ed);
    do_read(24'h000001, 1'b0);
    total++; if (r_lat != el) $display("FAIL wrap_lat: got %0d want %0d", r_lat, el); else passed++;
    total++; if (r_data !== ed) $display("FAIL wrap_data: got %h want %h", r_data, ed); else passed++;
  endtask

  task automatic test_back_to_back();
    int el, gap;
    logic [23:0] a, prev_a;
    logic [31:0] ed;
    prev_a = 24'h000000;
    for (int t = 0; t < 12; t++) begin
      gap = (t == 0) ? 0 : $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 1) == 1) a = (prev_a & 24'hFFFFFC) + 24'd4 + 24'($urandom_range(0, 3));
      else a = 24'($urandom());
      prev_a = a;
      model_read(a, el, ed);
      do_read(a, 1'b0);
      total++; if (r_lat != el) $display("FAIL b2b_lat[%0d]: addr %h got %0d want %0d", t, a, r_lat, el); else passed++;
      total++; if (r_data !== ed) $display("FAIL b2b_data[%0d]: addr %h got %h want %h", t, a, r_data, ed); else passed++;
    end
  endtask

  task automatic test_oe_sck();
    total++; if (oe_err != 0) $display("FAIL oe_profile: got %0d violations want 0", oe_err); else passed++;
    total++; if (gap_err != 0) $display("FAIL sck_period: got %0d bad gaps want 0", gap_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_unaligned();
    test_basic();
    test_cont();
    test_busy_strobe();
    test_wrap();
    test_back_to_back();
    test_oe_sck();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
